// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the two-port sram controller.
// State and port enums plus the counter sizing helper used by sram_ctrl_arb.
package sram_ctrl_pkg;

  localparam int SRAM_DW = 16;
  localparam int SRAM_AW = 8;

  typedef enum logic [2:0] {INIT, IDLE, SETUP, ACCESS, HOLD} state_e;
  typedef enum logic {PORT_A, PORT_B} port_e;

  // One counter serves both the init pulse and the access phase.
  function automatic int cnt_width(input int access_cycles, input int init_cycles);
    return $clog2(((access_cycles > init_cycles) ? access_cycles : init_cycles) + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the port that did not win last time is granted.
// last_grant only advances when the controller accepts the grant.
module rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output port_e      grant
);

  port_e last_grant;

  always_comb begin
    grant = PORT_A;
    if (req == 2'b11) begin
      grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (req[1]) begin
      grant = PORT_B;
    end
  end

  // Starting from B means A wins the first tie after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= PORT_B;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/sram_ctrl_arb.sv
// Two-requester controller for the async sram: round-robin arbitration, init pulse,
// and SETUP/ACCESS/HOLD sequencing of the active-low strobes and the shared data bus.
module sram_ctrl_arb
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = SRAM_DW,
  parameter int ADDR_WIDTH    = SRAM_AW,
  parameter int ACCESS_CYCLES = 2,
  parameter int INIT_CYCLES   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_ce_n,
  output logic                  sram_we_n,
  output logic                  sram_oe_n,
  output logic                  sram_rst
);

  localparam int CW = cnt_width(ACCESS_CYCLES, INIT_CYCLES);

  state_e                state;
  logic [CW-1:0]         cnt;
  port_e                 grant;
  port_e                 owner;
  logic                  accept;
  logic                  we_q;
  logic                  drive_en;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign accept    = (state == IDLE) && (a_req || b_req);
  assign busy      = (state != IDLE);
  assign sram_data = drive_en ? wdata_q : 'z;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({b_req, a_req}),
    .accept (accept),
    .grant  (grant)
  );

  always_comb begin
    sel_we    = a_we;
    sel_addr  = a_addr;
    sel_wdata = a_wdata;
    if (grant == PORT_B) begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end
  end

  // All strobes and acks are registered so they change only on clock edges (or reset).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      cnt       <= '0;
      owner     <= PORT_A;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      drive_en  <= 1'b0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_rst  <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        INIT: begin
          if (cnt == CW'(INIT_CYCLES)) begin
            sram_rst <= 1'b0;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            sram_rst <= 1'b1;
            cnt      <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            owner     <= grant;
            we_q      <= sel_we;
            sram_addr <= sel_addr;
            wdata_q   <= sel_wdata;
            drive_en  <= sel_we;
            sram_ce_n <= 1'b0;
            cnt       <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          sram_we_n <= ~we_q;
          sram_oe_n <= we_q;
          cnt       <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          // Read data is sampled on the same edge that releases OE_n.
          if (cnt == CW'(ACCESS_CYCLES - 1)) begin
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            cnt       <= '0;
            state     <= HOLD;
            if (owner == PORT_A) begin
              a_ack <= 1'b1;
              if (!we_q) a_rdata <= sram_data;
            end else begin
              b_ack <= 1'b1;
              if (!we_q) b_rdata <= sram_data;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          sram_ce_n <= 1'b1;
          drive_en  <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl_arb.sv
// Randomized self-checking bench for sram_ctrl_arb with a behavioural sram and a
// reference memory / round-robin model computed from the access rules.
module tb_sram_ctrl_arb;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int AC = 2;
  localparam int IC = 2;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  logic          clk;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, b_ack, busy;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_data;
  logic          sram_ce_n, sram_we_n, sram_oe_n, sram_rst;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] sram_mem [256];
  logic [DW-1:0] ref_mem  [256];
  logic [DW-1:0] exp_a_rdata, exp_b_rdata;
  int            exp_last;
  op_t           qa[$];
  op_t           qb[$];

  sram_ctrl_arb #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACCESS_CYCLES(AC), .INIT_CYCLES(IC)
  ) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .busy(busy), .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_rst(sram_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] image_word(input int addr);
    case (addr)
      50:      return 16'd115;
      124:     return 16'h3779;
      242:     return 16'd120;
      default: return 16'd0;
    endcase
  endfunction

  // Behavioural async sram: init image on sram_rst, write while CE/WE low, read drives bus.
  always @(posedge clk) begin
    if (sram_rst) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= image_word(i);
    end else if (!sram_ce_n && !sram_we_n) begin
      sram_mem[sram_addr] <= sram_data;
    end
  end
  assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 'z;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Bus-protocol invariants sampled every cycle outside reset.
  logic          prev_we_low, prev_a_ack, prev_b_ack;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;
  always @(negedge clk) begin
    if (reset) begin
      prev_we_low = 1'b0;
      prev_a_ack  = 1'b0;
      prev_b_ack  = 1'b0;
    end else begin
      checkOutput("we_oe_excl", 32'(!sram_we_n && !sram_oe_n), 32'd0);
      checkOutput("ack_onehot", 32'(a_ack && b_ack), 32'd0);
      checkOutput("a_ack_width", 32'(a_ack && prev_a_ack), 32'd0);
      checkOutput("b_ack_width", 32'(b_ack && prev_b_ack), 32'd0);
      if (!sram_we_n && prev_we_low) begin
        checkOutput("we_addr_stable", 32'(sram_addr), 32'(prev_addr));
        checkOutput("we_data_stable", 32'(sram_data), 32'(prev_data));
      end
      if (!sram_oe_n && !sram_ce_n) checkOutput("read_bus", 32'(sram_data), 32'(sram_mem[sram_addr]));
      prev_we_low = !sram_we_n;
      prev_addr   = sram_addr;
      prev_data   = sram_data;
      prev_a_ack  = a_ack;
      prev_b_ack  = b_ack;
    end
  end

  function automatic int nextPort();
    if (qa.size() > 0 && qb.size() > 0) return (exp_last == 1) ? 0 : 1;
    if (qa.size() > 0) return 0;
    return 1;
  endfunction

  task automatic drivePorts();
    a_req = (qa.size() > 0);
    b_req = (qb.size() > 0);
    if (qa.size() > 0) begin a_we = qa[0].we; a_addr = qa[0].addr; a_wdata = qa[0].data; end
    if (qb.size() > 0) begin b_we = qb[0].we; b_addr = qb[0].addr; b_wdata = qb[0].data; end
  endtask

  task automatic doReset();
    reset = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ce_n", 32'(sram_ce_n), 32'd1);
    checkOutput("rst_we_oe", 32'({sram_we_n, sram_oe_n}), 32'd3);
    checkOutput("rst_acks", 32'({a_ack, b_ack}), 32'd0);
    checkOutput("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    checkOutput("rst_sram_rst", 32'(sram_rst), 32'd0);
    checkOutput("rst_addr", 32'(sram_addr), 32'd0);
    for (int i = 0; i < 256; i++) ref_mem[i] = image_word(i);
    exp_a_rdata = '0;
    exp_b_rdata = '0;
    exp_last    = 1;
    reset = 1'b0;
    begin
      int rst_cycles = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (sram_rst) rst_cycles++;
      end
      checkOutput("init_pulse_len", 32'(rst_cycles), 32'(IC));
    end
    checkOutput("idle_after_init", 32'(busy), 32'd0);
  endtask

  // Drains qa/qb through the DUT, checking grant order, ack timing and read data.
  task automatic applyStimulus();
    int  cycles = 0;
    int  last_ack = -1;
    int  exp_port;
    int  port;
    op_t op;
    exp_port = nextPort();
    drivePorts();
    while (qa.size() > 0 || qb.size() > 0) begin
      @(negedge clk);
      cycles++;
      if (cycles > 2000) begin
        checkOutput("ack_timeout", 32'd0, 32'd1);
        qa.delete();
        qb.delete();
        drivePorts();
        break;
      end
      if (a_ack || b_ack) begin
        port = b_ack ? 1 : 0;
        checkOutput("grant_order", 32'(port), 32'(exp_port));
        checkOutput("ack_timing", 32'((last_ack < 0) ? cycles : cycles - last_ack),
                    32'((last_ack < 0) ? 2 + AC : 3 + AC));
        if ((port == 0 && qa.size() == 0) || (port == 1 && qb.size() == 0)) begin
          checkOutput("spurious_ack", 32'(port), 32'(exp_port));
        end else begin
          op = (port == 0) ? qa.pop_front() : qb.pop_front();
          if (op.we) ref_mem[op.addr] = op.data;
          else if (port == 0) exp_a_rdata = ref_mem[op.addr];
          else exp_b_rdata = ref_mem[op.addr];
        end
        checkOutput("a_rdata", 32'(a_rdata), 32'(exp_a_rdata));
        checkOutput("b_rdata", 32'(b_rdata), 32'(exp_b_rdata));
        exp_last = port;
        last_ack = cycles;
        exp_port = nextPort();
        drivePorts();
      end
    end
    @(negedge clk);
  endtask

  function automatic op_t mkOp(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    op_t o;
    o.we   = we;
    o.addr = addr;
    o.data = data;
    return o;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    a_we = 0; a_addr = '0; a_wdata = '0;
    b_we = 0; b_addr = '0; b_wdata = '0;
    doReset();

    // Init image reads, one port at a time.
    qa.push_back(mkOp(1'b0, 8'd50, '0));
    applyStimulus();
    checkOutput("t1_a_50", 32'(a_rdata), 32'd115);
    qa.push_back(mkOp(1'b0, 8'd124, '0));
    applyStimulus();
    checkOutput("t1_a_124", 32'(a_rdata), 32'h3779);
    qb.push_back(mkOp(1'b0, 8'd242, '0));
    applyStimulus();
    checkOutput("t1_b_242", 32'(b_rdata), 32'd120);

    // Write from A, read back from B.
    qa.push_back(mkOp(1'b1, 8'h10, 16'hBEEF));
    applyStimulus();
    qb.push_back(mkOp(1'b0, 8'h10, '0));
    applyStimulus();
    checkOutput("t2_b_beef", 32'(b_rdata), 32'hBEEF);

    // Contending writers after a fresh reset: A first, then strict alternation.
    doReset();
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mkOp(1'b1, 8'(8'h40 + i), 16'($urandom)));
      qb.push_back(mkOp(1'b1, 8'(8'h80 + i), 16'($urandom)));
    end
    applyStimulus();
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mkOp(1'b0, 8'(8'h80 + i), '0));
      qb.push_back(mkOp(1'b0, 8'(8'h40 + i), '0));
    end
    applyStimulus();

    // Back-to-back reads on A alone exercise the minimum period.
    for (int i = 0; i < 3; i++) qa.push_back(mkOp(1'b0, 8'(8'h40 + i), '0));
    applyStimulus();

    // Randomized mixed traffic over a small address pool so reads hit earlier writes.
    for (int r = 0; r < 8; r++) begin
      int na = $urandom_range(0, 5);
      int nb = $urandom_range(0, 5);
      for (int i = 0; i < na; i++)
        qa.push_back(mkOp(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 16'($urandom)));
      for (int i = 0; i < nb; i++)
        qb.push_back(mkOp(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 16'($urandom)));
      applyStimulus();
    end

    // Reset in the middle of a write's ACCESS phase aborts it without an ack.
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wdata = 16'hA5A5;
    begin
      int waited = 0;
      while (sram_we_n && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("t4_reached_access", 32'(sram_we_n), 32'd0);
    end
    #2 reset = 1'b1;
    #1;
    checkOutput("t4_strobes_off", 32'({sram_ce_n, sram_we_n, sram_oe_n}), 32'd7);
    checkOutput("t4_no_ack", 32'({a_ack, b_ack}), 32'd0);
    a_req = 1'b0;
    doReset();
    qa.push_back(mkOp(1'b0, 8'h20, '0));
    applyStimulus();
    checkOutput("t4_read_20", 32'(a_rdata), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
